// File: rtl/pe_block_4x4_ctrl.sv
// Tile sequencer for a 4x4 broadcast MAC block: clear, stream K operand beats, drain, hand off result.
// Optional PE_CTRL_PERF_CNT_EN adds saturating stall/tile counters.
module pe_block_4x4_ctrl #(
   parameter int InDataWidth  = 8,
   parameter int OutDataWidth = 32,
   parameter int KWidth       = 16,
   parameter int MacLatency   = 1
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        start_i,
   input  logic [KWidth-1:0]           k_len_i,
   output logic                        busy_o,
   output logic                        done_o,
   input  logic                        op_valid_i,
   output logic                        op_ready_o,
   input  logic [4*InDataWidth-1:0]    op_a_i,
   input  logic [4*InDataWidth-1:0]    op_b_i,
   output logic [4*InDataWidth-1:0]    pe_a_o,
   output logic [4*InDataWidth-1:0]    pe_b_o,
   output logic                        pe_a_valid_o,
   output logic                        pe_b_valid_o,
   output logic                        pe_acc_clr_o,
   output logic                        pe_init_save_o,
   input  logic [16*OutDataWidth-1:0]  pe_c_i,
   output logic                        res_valid_o,
   input  logic                        res_ready_i,
   output logic [16*OutDataWidth-1:0]  res_c_o
`ifdef PE_CTRL_PERF_CNT_EN
   ,
   output logic [31:0]                 stall_cnt_o,
   output logic [31:0]                 tile_cnt_o
`endif
);

   localparam int DrainW = $clog2(MacLatency + 2);
   localparam logic [DrainW-1:0] DrainLast = DrainW'(MacLatency);
   localparam logic [DrainW-1:0] DrainPenult = DrainW'(MacLatency - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_DONE
   } state_e;

   state_e                       state_q;
   logic [KWidth-1:0]            k_len_q;
   logic [KWidth-1:0]            beat_cnt_q;
   logic [DrainW-1:0]            drain_cnt_q;
   logic [4*InDataWidth-1:0]     pe_a_q;
   logic [4*InDataWidth-1:0]     pe_b_q;
   logic                         pe_vld_q;
   logic                         clr_q;
   logic                         save_q;
   logic                         busy_q;
   logic                         res_valid_q;
   logic [16*OutDataWidth-1:0]   res_c_q;
   logic                         accept;

   // Ready falls as soon as the count reaches k_len, so no extra beat slips in.
   assign op_ready_o     = (state_q == S_STREAM) && (beat_cnt_q != k_len_q);
   assign accept         = op_valid_i & op_ready_o;
   assign done_o         = res_valid_q & res_ready_i;
   assign busy_o         = busy_q;
   assign pe_a_o         = pe_a_q;
   assign pe_b_o         = pe_b_q;
   assign pe_a_valid_o   = pe_vld_q;
   assign pe_b_valid_o   = pe_vld_q;
   assign pe_acc_clr_o   = clr_q;
   assign pe_init_save_o = save_q;
   assign res_valid_o    = res_valid_q;
   assign res_c_o        = res_c_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         k_len_q     <= '0;
         beat_cnt_q  <= '0;
         drain_cnt_q <= '0;
         pe_a_q      <= '0;
         pe_b_q      <= '0;
         pe_vld_q    <= 1'b0;
         clr_q       <= 1'b0;
         save_q      <= 1'b0;
         busy_q      <= 1'b0;
         res_valid_q <= 1'b0;
         res_c_q     <= '0;
      end else begin
         pe_vld_q <= accept;
         if (accept) begin
            pe_a_q <= op_a_i;
            pe_b_q <= op_b_i;
         end
         clr_q  <= 1'b0;
         save_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  k_len_q     <= k_len_i;
                  beat_cnt_q  <= '0;
                  drain_cnt_q <= '0;
                  clr_q       <= 1'b1;
                  busy_q      <= 1'b1;
                  state_q     <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               state_q <= (k_len_q == '0) ? S_DRAIN : S_STREAM;
            end
            S_STREAM: begin
               if (accept) begin
                  beat_cnt_q <= beat_cnt_q + KWidth'(1);
                  if (beat_cnt_q + KWidth'(1) == k_len_q) begin
                     state_q <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               // One cycle for the operand register plus MacLatency for the MACs.
               drain_cnt_q <= drain_cnt_q + DrainW'(1);
               if (drain_cnt_q == DrainPenult) begin
                  save_q <= 1'b1;
               end
               if (drain_cnt_q == DrainLast) begin
                  res_c_q     <= pe_c_i;
                  res_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end
            end
            S_DONE: begin
               if (res_ready_i) begin
                  res_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

`ifdef PE_CTRL_PERF_CNT_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] tile_cnt_q;

   assign stall_cnt_o = stall_cnt_q;
   assign tile_cnt_o  = tile_cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_q <= '0;
         tile_cnt_q  <= '0;
      end else begin
         if ((state_q == S_STREAM) && !op_valid_i && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         if (done_o && (tile_cnt_q != '1)) begin
            tile_cnt_q <= tile_cnt_q + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pe_block_4x4_ctrl.sv
// Self-checking bench for pe_block_4x4_ctrl with a behavioural 4x4 MAC block model.
// Compile with PE_CTRL_PERF_CNT_EN to also cover the performance counters.
module tb_pe_block_4x4_ctrl;
   localparam int IW = 8;
   localparam int OW = 32;
   localparam int KW = 16;
   localparam int ML = 1;

   logic              clk = 1'b0;
   logic              rst_i = 1'b1;
   logic              start_i = 1'b0;
   logic [KW-1:0]     k_len_i = '0;
   logic              busy_o, done_o;
   logic              op_valid_i = 1'b0;
   logic              op_ready_o;
   logic [4*IW-1:0]   op_a_i = '0, op_b_i = '0;
   logic [4*IW-1:0]   pe_a_o, pe_b_o;
   logic              pe_a_valid_o, pe_b_valid_o, pe_acc_clr_o, pe_init_save_o;
   logic [16*OW-1:0]  pe_c_i;
   logic              res_valid_o;
   logic              res_ready_i = 1'b0;
   logic [16*OW-1:0]  res_c_o;
`ifdef PE_CTRL_PERF_CNT_EN
   logic [31:0]       stall_cnt_o, tile_cnt_o;
`endif

   int errors = 0;
   int checks = 0;
   int ba [32][4];
   int bb [32][4];
   int expv [16];

   always #5 clk = ~clk;

   pe_block_4x4_ctrl #(
      .InDataWidth(IW), .OutDataWidth(OW), .KWidth(KW), .MacLatency(ML)
   ) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .k_len_i(k_len_i),
      .busy_o(busy_o), .done_o(done_o),
      .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
      .op_a_i(op_a_i), .op_b_i(op_b_i),
      .pe_a_o(pe_a_o), .pe_b_o(pe_b_o),
      .pe_a_valid_o(pe_a_valid_o), .pe_b_valid_o(pe_b_valid_o),
      .pe_acc_clr_o(pe_acc_clr_o), .pe_init_save_o(pe_init_save_o),
      .pe_c_i(pe_c_i),
      .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_c_o(res_c_o)
`ifdef PE_CTRL_PERF_CNT_EN
      , .stall_cnt_o(stall_cnt_o), .tile_cnt_o(tile_cnt_o)
`endif
   );

   // Behavioural MAC block: C[m][n] += A[m]*B[n] per valid beat, visible ML cycles later.
   logic signed [OW-1:0] acc [16];
   logic [16*OW-1:0]     acc_flat;

   initial for (int i = 0; i < 16; i++) acc[i] = '0;

   always_comb begin
      acc_flat = '0;
      for (int i = 0; i < 16; i++) acc_flat[i*OW +: OW] = acc[i];
   end

   always @(posedge clk) begin
      if (pe_acc_clr_o) begin
         for (int i = 0; i < 16; i++) acc[i] <= '0;
      end else if (pe_a_valid_o) begin
         for (int m = 0; m < 4; m++)
            for (int n = 0; n < 4; n++)
               acc[m*4+n] <= acc[m*4+n] + $signed(pe_a_o[m*IW +: IW]) * $signed(pe_b_o[n*IW +: IW]);
      end
   end

   generate
      if (ML == 1) begin : g_lat1
         assign pe_c_i = acc_flat;
      end else begin : g_latn
         logic [16*OW-1:0] dly [ML-1];
         always @(posedge clk) begin
            dly[0] <= acc_flat;
            for (int i = 1; i < ML-1; i++) dly[i] <= dly[i-1];
         end
         assign pe_c_i = dly[ML-2];
      end
   endgenerate

   task automatic fill_random(input int n);
      for (int i = 0; i < n; i++)
         for (int j = 0; j < 4; j++) begin
            ba[i][j] = int'($urandom_range(0, 255)) - 128;
            bb[i][j] = int'($urandom_range(0, 255)) - 128;
         end
   endtask

   task automatic drive_beat(input int idx);
      int j;
      j = (idx < 32) ? idx : 31;
      for (int m = 0; m < 4; m++) begin
         op_a_i[m*IW +: IW] = ba[j][m][IW-1:0];
         op_b_i[m*IW +: IW] = bb[j][m][IW-1:0];
      end
   endtask

   // vmode: 0 = valid every cycle, 1 = pattern 1,0,0,1,0,1 over STREAM cycles, 2 = random valid.
   task automatic run_tile(input string nm, input int k, input int vmode, input int hold);
      int cyc, idx, pat, vpulses, clrs, last_acc, save_cyc, stall_exp, bad, vmis;
      int patt [6];
      logic [16*OW-1:0] held;
`ifdef PE_CTRL_PERF_CNT_EN
      logic [31:0] stall0, tile0;
`endif
      patt = '{1, 0, 0, 1, 0, 1};
      for (int i = 0; i < 16; i++) expv[i] = 0;
      for (int i = 0; i < k; i++)
         for (int m = 0; m < 4; m++)
            for (int n = 0; n < 4; n++)
               expv[m*4+n] += ba[i][m] * bb[i][n];
`ifdef PE_CTRL_PERF_CNT_EN
      stall0 = stall_cnt_o;
      tile0  = tile_cnt_o;
`endif
      @(posedge clk); #1;
      start_i = 1'b1; k_len_i = KW'(k); res_ready_i = 1'b0;
      @(posedge clk); #1;
      start_i = 1'b0;
      cyc = 0; idx = 0; pat = 0; vpulses = 0; clrs = 0;
      last_acc = -1; save_cyc = -1; stall_exp = 0; vmis = 0;
      while (cyc < 300 && !res_valid_o) begin
         case (vmode)
            0: op_valid_i = 1'b1;
            1: begin
               op_valid_i = 1'b0;
               if (op_ready_o) begin
                  op_valid_i = (patt[pat % 6] != 0);
                  pat++;
               end
            end
            default: op_valid_i = ($urandom_range(0, 3) != 0);
         endcase
         drive_beat(idx);
         @(negedge clk);
         if (pe_acc_clr_o) clrs++;
         if (pe_a_valid_o) vpulses++;
         if (pe_a_valid_o !== pe_b_valid_o) vmis++;
         if (pe_init_save_o) save_cyc = cyc;
         if (op_ready_o && !op_valid_i) stall_exp++;
         if (op_valid_i && op_ready_o) begin
            idx++;
            last_acc = cyc;
         end
         @(posedge clk); #1;
         cyc++;
      end
      op_valid_i = 1'b0;
      checks++;
      if (!res_valid_o) begin
         errors++;
         $display("FAIL %s timeout: res_valid_o=%0b after %0d cycles, required 1", nm, res_valid_o, cyc);
         return;
      end
      checks++;
      if (idx !== k) begin
         errors++; $display("FAIL %s accepted beats: got %0d required %0d", nm, idx, k);
      end
      checks++;
      if (vpulses !== k || vmis != 0) begin
         errors++; $display("FAIL %s pe valid pulses: got %0d (a/b mismatch %0d) required %0d", nm, vpulses, vmis, k);
      end
      checks++;
      if (clrs !== 1) begin
         errors++; $display("FAIL %s acc clear cycles: got %0d required 1", nm, clrs);
      end
      bad = -1;
      for (int i = 0; i < 16; i++)
         if ($signed(res_c_o[i*OW +: OW]) !== expv[i] && bad < 0) bad = i;
      checks++;
      if (bad >= 0) begin
         errors++;
         $display("FAIL %s result c[%0d][%0d]: got %0d required %0d", nm, bad/4, bad%4,
                  $signed(res_c_o[bad*OW +: OW]), expv[bad]);
      end
      checks++;
      if (cyc - save_cyc !== 1 || (k > 0 && save_cyc - last_acc !== ML + 1)) begin
         errors++;
         $display("FAIL %s latency: last beat->save %0d (required %0d), save->res_valid %0d (required 1)",
                  nm, save_cyc - last_acc, ML + 1, cyc - save_cyc);
      end
      held = res_c_o;
      bad = 0;
      for (int h = 0; h < hold; h++) begin
         start_i = (h == hold / 2);
         @(negedge clk);
         if (!res_valid_o || !busy_o || done_o || op_ready_o || res_c_o !== held) bad++;
         @(posedge clk); #1;
         start_i = 1'b0;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL %s hold in DONE: %0d bad cycles of %0d, required 0", nm, bad, hold);
      end
      res_ready_i = 1'b1;
      @(negedge clk);
      checks++;
      if (done_o !== 1'b1 || res_valid_o !== 1'b1) begin
         errors++; $display("FAIL %s handshake: done_o=%0b res_valid_o=%0b required 1/1", nm, done_o, res_valid_o);
      end
      @(posedge clk); #1;
      res_ready_i = 1'b0;
      @(negedge clk);
      checks++;
      if (done_o !== 1'b0 || res_valid_o !== 1'b0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL %s after handshake: done=%0b valid=%0b busy=%0b required 0/0/0", nm, done_o, res_valid_o, busy_o);
      end
      @(posedge clk); #1;
      checks++;
      if (busy_o !== 1'b0 || pe_acc_clr_o !== 1'b0) begin
         errors++; $display("FAIL %s start in DONE ignored: busy=%0b clr=%0b required 0/0", nm, busy_o, pe_acc_clr_o);
      end
`ifdef PE_CTRL_PERF_CNT_EN
      checks++;
      if (stall_cnt_o - stall0 !== ((vmode == 1) ? 32'd3 : (vmode == 0) ? 32'd0 : 32'(stall_exp))) begin
         errors++; $display("FAIL %s stall count delta: got %0d required %0d", nm, stall_cnt_o - stall0,
                            (vmode == 1) ? 3 : (vmode == 0) ? 0 : stall_exp);
      end
      checks++;
      if (tile_cnt_o - tile0 !== 32'd1) begin
         errors++; $display("FAIL %s tile count delta: got %0d required 1", nm, tile_cnt_o - tile0);
      end
`endif
   endtask

   task automatic check_all_zero(input string nm);
      checks++;
      if (busy_o !== 1'b0 || done_o !== 1'b0 || op_ready_o !== 1'b0 || pe_a_o !== '0 || pe_b_o !== '0 ||
          pe_a_valid_o !== 1'b0 || pe_b_valid_o !== 1'b0 || pe_acc_clr_o !== 1'b0 ||
          pe_init_save_o !== 1'b0 || res_valid_o !== 1'b0 || res_c_o !== '0) begin
         errors++;
         $display("FAIL %s outputs: busy=%0b ready=%0b pe_a=%h pe_vld=%0b clr=%0b save=%0b res_vld=%0b res_nz=%0b required all 0",
                  nm, busy_o, op_ready_o, pe_a_o, pe_a_valid_o, pe_acc_clr_o, pe_init_save_o, res_valid_o, |res_c_o);
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_i = 1'b0;
      check_all_zero("reset");
`ifdef PE_CTRL_PERF_CNT_EN
      checks++;
      if (stall_cnt_o !== 32'd0 || tile_cnt_o !== 32'd0) begin
         errors++; $display("FAIL reset counters: stall=%0d tile=%0d required 0/0", stall_cnt_o, tile_cnt_o);
      end
`endif
   endtask

   task automatic test_basic();
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 4; j++) begin
            ba[i][j] = j + 1;
            bb[i][j] = 1;
         end
      run_tile("basic_k4", 4, 0, 10);
      checks++;
      if ($signed(res_c_o[15*OW +: OW]) !== 0 && expv[15] !== 16) begin
         errors++; $display("FAIL basic_k4 model row3: got %0d required 16", expv[15]);
      end
   endtask

   task automatic test_zero_len();
      fill_random(4);
      run_tile("zero_len", 0, 0, 2);
   endtask

   task automatic test_gapped();
      fill_random(8);
      run_tile("gapped_k3", 3, 1, 1);
   endtask

   task automatic test_reset_mid();
      int idx, cyc;
      fill_random(8);
      @(posedge clk); #1;
      start_i = 1'b1; k_len_i = KW'(4);
      @(posedge clk); #1;
      start_i = 1'b0;
      idx = 0; cyc = 0;
      while (idx < 2 && cyc < 50) begin
         op_valid_i = 1'b1;
         drive_beat(idx);
         @(negedge clk);
         if (op_valid_i && op_ready_o) idx++;
         @(posedge clk); #1;
         cyc++;
      end
      checks++;
      if (idx !== 2) begin
         errors++; $display("FAIL reset_mid beats before reset: got %0d required 2", idx);
      end
      op_valid_i = 1'b1;
      rst_i = 1'b1;
      @(posedge clk); #1;
      rst_i = 1'b0;
      op_valid_i = 1'b0;
      check_all_zero("reset_mid");
      @(posedge clk); #1;
      check_all_zero("reset_mid_next");
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            ba[i][j] = 2;
            bb[i][j] = 2;
         end
      run_tile("after_reset_k2", 2, 0, 0);
   endtask

   task automatic test_random();
      for (int t = 0; t < 8; t++) begin
         fill_random(12);
         run_tile($sformatf("random_%0d", t), int'($urandom_range(1, 8)), 2, int'($urandom_range(0, 3)));
      end
   endtask

   task automatic test_back_to_back();
      for (int t = 0; t < 3; t++) begin
         fill_random(6);
         run_tile($sformatf("b2b_%0d", t), t + 1, 0, 0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_len();
      test_gapped();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global timeout");
      $fatal(1, "timeout");
   end
endmodule
